// File: rtl/escalonador_rr_if.sv
// escalonador_rr_if: control/status bundle between a CPU core and the round-robin scheduler
// master = core/testbench side, slave = scheduler side.
// Inputs to scheduler: inicia, num_proc, instr_valida, pc, io_req, fim_processo, io_done, io_pid.
// Outputs from scheduler: troca_contexto, pc_destino, processo_atual, ocioso, concluido, erro.
interface escalonador_rr_if #(parameter int N_PROC = 10);
  localparam int PID_W = $clog2(N_PROC + 1);
  logic             inicia;
  logic [PID_W-1:0] num_proc;
  logic             instr_valida;
  logic [31:0]      pc;
  logic             io_req;
  logic             fim_processo;
  logic             io_done;
  logic [PID_W-1:0] io_pid;
  logic             troca_contexto;
  logic [31:0]      pc_destino;
  logic [PID_W-1:0] processo_atual;
  logic             ocioso;
  logic             concluido;
  logic             erro;
  modport master (
    output inicia, num_proc, instr_valida, pc, io_req, fim_processo, io_done, io_pid,
    input  troca_contexto, pc_destino, processo_atual, ocioso, concluido, erro
  );
  modport slave (
    input  inicia, num_proc, instr_valida, pc, io_req, fim_processo, io_done, io_pid,
    output troca_contexto, pc_destino, processo_atual, ocioso, concluido, erro
  );
endinterface

// File: rtl/escalonador_rr.sv
// escalonador_rr: round-robin process scheduler with quantum preemption and IO blocking
// Ports: clock, reset (async active-high), bus (escalonador_rr_if.slave).
// All outputs are registered; a dispatch decided in SWITCH appears on the following cycle.
module escalonador_rr #(
  parameter int N_PROC       = 10,
  parameter int QUANTUM      = 8,
  parameter int BASE_PROC    = 300,
  parameter int TAM_PARTICAO = 300
) (
  input logic              clock,
  input logic              reset,
  escalonador_rr_if.slave  bus
);
  localparam int PID_W = $clog2(N_PROC + 1);
  localparam int CUR_W = $clog2(N_PROC);
  typedef enum logic [1:0] {IDLE, SWITCH, RUN, FIM} state_t;
  state_t            state_q, state_d;
  logic [N_PROC-1:0] live_q, live_d, blocked_q, blocked_d, blk_set, blk_clr, ready;
  logic [31:0]       pc_arr_q [N_PROC];
  logic [31:0]       pc_arr_d [N_PROC];
  logic [CUR_W-1:0]  cursor_q, cursor_d, k;
  logic [7:0]        cnt_q, cnt_d;
  logic              troca_q, troca_d, ocioso_q, ocioso_d, concl_q, concl_d, erro_q, erro_d;
  logic [31:0]       pc_dest_q, pc_dest_d;
  logic [PID_W-1:0]  proc_q, proc_d;
  logic              found, start_ok;
  assign ready    = live_q & ~blocked_q;
  assign start_ok = bus.num_proc != '0 && bus.num_proc <= PID_W'(N_PROC);
  always_comb begin
    found = 1'b0;
    k     = '0;
    // descending scan so the nearest slot after the cursor is written last and wins;
    // j = N_PROC lands back on the cursor itself, re-selecting a lone ready process
    for (int j = N_PROC; j >= 1; j--)
      for (int i = 0; i < N_PROC; i++)
        if (i == (int'(cursor_q) + j) % N_PROC && ready[i]) begin
          found = 1'b1;
          k     = CUR_W'(i);
        end
  end
  always_comb begin
    state_d   = state_q;
    live_d    = live_q;
    blocked_d = blocked_q;
    pc_arr_d  = pc_arr_q;
    cursor_d  = cursor_q;
    cnt_d     = cnt_q;
    troca_d   = 1'b0;
    pc_dest_d = pc_dest_q;
    proc_d    = proc_q;
    ocioso_d  = 1'b0;
    concl_d   = concl_q;
    erro_d    = 1'b0;
    blk_set   = '0;
    for (int i = 0; i < N_PROC; i++)
      blk_clr[i] = bus.io_done && bus.io_pid == PID_W'(i + 1);
    case (state_q)
      IDLE, FIM: if (bus.inicia) begin
        if (start_ok) begin
          for (int i = 0; i < N_PROC; i++) begin
            live_d[i]   = PID_W'(i) < bus.num_proc;
            pc_arr_d[i] = 32'(BASE_PROC + i * TAM_PARTICAO);
          end
          blocked_d = '0;
          cursor_d  = CUR_W'(N_PROC - 1);
          concl_d   = 1'b0;
          proc_d    = '0;
          state_d   = SWITCH;
        end else erro_d = 1'b1;
      end
      SWITCH: begin
        if (live_q == '0) begin
          state_d = FIM;
          concl_d = 1'b1;
          proc_d  = '0;
        end else if (found) begin
          troca_d   = 1'b1;
          pc_dest_d = pc_arr_q[k];
          proc_d    = PID_W'(k) + PID_W'(1);
          cnt_d     = '0;
          cursor_d  = k;
          state_d   = RUN;
        end else ocioso_d = 1'b1;
      end
      RUN: begin
        if (bus.instr_valida) cnt_d = cnt_q + 8'd1;
        if (bus.fim_processo) begin
          live_d[cursor_q] = 1'b0;
          state_d          = SWITCH;
        end else if (bus.io_req) begin
          pc_arr_d[cursor_q] = bus.pc;
          blk_set[cursor_q]  = 1'b1;
          state_d            = SWITCH;
        end else if (bus.instr_valida && cnt_q == 8'(QUANTUM - 1)) begin
          pc_arr_d[cursor_q] = bus.pc;
          state_d            = SWITCH;
        end
      end
      default: state_d = IDLE;
    endcase
    // a block request beats a simultaneous IO completion on the same slot
    blocked_d = (blocked_d & ~blk_clr) | blk_set;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      live_q    <= '0;
      blocked_q <= '0;
      pc_arr_q  <= '{default: '0};
      cursor_q  <= '0;
      cnt_q     <= '0;
      troca_q   <= 1'b0;
      pc_dest_q <= '0;
      proc_q    <= '0;
      ocioso_q  <= 1'b0;
      concl_q   <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= live_d;
      blocked_q <= blocked_d;
      pc_arr_q  <= pc_arr_d;
      cursor_q  <= cursor_d;
      cnt_q     <= cnt_d;
      troca_q   <= troca_d;
      pc_dest_q <= pc_dest_d;
      proc_q    <= proc_d;
      ocioso_q  <= ocioso_d;
      concl_q   <= concl_d;
      erro_q    <= erro_d;
    end
  end
  assign bus.troca_contexto = troca_q;
  assign bus.pc_destino     = pc_dest_q;
  assign bus.processo_atual = proc_q;
  assign bus.ocioso         = ocioso_q;
  assign bus.concluido      = concl_q;
  assign bus.erro           = erro_q;
endmodule
